// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - stimulus sequencer and y-code counter for a serial Moore FSM
//
// Purpose: buffers {clr, word} entries in a small FIFO, optionally pulses the
// FSM reset, shifts each word MSB-first onto fsm_x, then counts the non-zero
// fsm_y codes seen for that word and reports them with a one-cycle res_valid.
//
// Ports:
//   clk                 rising-edge clock shared with the FSM
//   rst                 asynchronous active-low reset
//   in_valid/in_ready   word handshake; in_data is sent MSB first
//   in_clr              pulse fsm_rst before this word
//   fsm_x, fsm_rst      registered drive to the FSM
//   fsm_y               FSM Moore output
//   busy                a word is in flight
//   res_valid           one-cycle pulse, cnt1/cnt2/cnt3 updated
//   cnt1, cnt2, cnt3    per-word counts of y = 01 / 10 / 11

module seq_stream_ctrl #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_clr,
    output logic              in_ready,
    output logic              fsm_x,
    output logic              fsm_rst,
    input  logic [1:0]        fsm_y,
    output logic              busy,
    output logic              res_valid,
    output logic [CW-1:0]     cnt1,
    output logic [CW-1:0]     cnt2,
    output logic [CW-1:0]     cnt3
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(WORD_W);

    localparam logic [IW-1:0]   IDX_TOP  = IW'(WORD_W - 1);
    localparam logic [CNTW-1:0] FIFO_MAX = CNTW'(DEPTH);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN
    } state_t;

    // ---------------- FIFO ----------------
    logic [WORD_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CNTW-1:0]   r_count;

    state_t            r_state;

    logic              w_push;
    logic              w_pop;
    logic [WORD_W:0]   w_head;
    logic              w_head_clr;
    logic [WORD_W-1:0] w_head_data;

    assign in_ready    = (r_count != FIFO_MAX) && rst;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_head      = r_mem[r_rd];
    assign w_head_clr  = w_head[WORD_W];
    assign w_head_data = w_head[WORD_W-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {in_clr, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // ---------------- Sequencer ----------------
    logic              r_first;
    logic              r_fsm_x;
    logic              r_fsm_rst;
    logic [WORD_W-1:0] r_shift;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_acc1;
    logic [CW-1:0]     r_acc2;
    logic [CW-1:0]     r_acc3;
    logic [CW-1:0]     r_cnt1;
    logic [CW-1:0]     r_cnt2;
    logic [CW-1:0]     r_cnt3;
    logic              r_res_valid;

    logic [CW-1:0]     w_acc1_nxt;
    logic [CW-1:0]     w_acc2_nxt;
    logic [CW-1:0]     w_acc3_nxt;

    // Accumulator values after counting the current fsm_y sample (saturating).
    always_comb begin
        w_acc1_nxt = r_acc1;
        w_acc2_nxt = r_acc2;
        w_acc3_nxt = r_acc3;
        if (fsm_y == 2'b01 && r_acc1 != CNT_MAX) w_acc1_nxt = r_acc1 + CW'(1);
        if (fsm_y == 2'b10 && r_acc2 != CNT_MAX) w_acc2_nxt = r_acc2 + CW'(1);
        if (fsm_y == 2'b11 && r_acc3 != CNT_MAX) w_acc3_nxt = r_acc3 + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_first     <= 1'b1;
            r_fsm_x     <= 1'b0;
            r_fsm_rst   <= 1'b1;
            r_shift     <= '0;
            r_idx       <= '0;
            r_acc1      <= '0;
            r_acc2      <= '0;
            r_acc3      <= '0;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_cnt3      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_fsm_x   <= 1'b0;
                    r_fsm_rst <= 1'b0;
                    if (w_pop) begin
                        if (w_head_clr || r_first) begin
                            r_state   <= S_CLR;
                            r_fsm_rst <= 1'b1;
                            r_shift   <= w_head_data;
                        end else begin
                            // fsm_x carries the current bit; r_shift holds the rest.
                            r_state <= S_SHIFT;
                            r_fsm_x <= w_head_data[WORD_W-1];
                            r_shift <= {w_head_data[WORD_W-2:0], 1'b0};
                            r_idx   <= IDX_TOP;
                            r_acc1  <= '0;
                            r_acc2  <= '0;
                            r_acc3  <= '0;
                        end
                    end
                end
                S_CLR: begin
                    r_first   <= 1'b0;
                    r_fsm_rst <= 1'b0;
                    r_state   <= S_SHIFT;
                    r_fsm_x   <= r_shift[WORD_W-1];
                    r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
                    r_idx     <= IDX_TOP;
                    r_acc1    <= '0;
                    r_acc2    <= '0;
                    r_acc3    <= '0;
                end
                S_SHIFT: begin
                    // The Moore response to the MSB only shows up one cycle
                    // later, so the first SHIFT cycle takes no sample.
                    if (r_idx != IDX_TOP) begin
                        r_acc1 <= w_acc1_nxt;
                        r_acc2 <= w_acc2_nxt;
                        r_acc3 <= w_acc3_nxt;
                    end
                    if (r_idx == '0) begin
                        r_state <= S_DRAIN;
                        r_fsm_x <= 1'b0;
                    end else begin
                        r_fsm_x <= r_shift[WORD_W-1];
                        r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                        r_idx   <= r_idx - IW'(1);
                    end
                end
                S_DRAIN: begin
                    // Gap bit: its sample is the response to bit 0.
                    r_acc1      <= w_acc1_nxt;
                    r_acc2      <= w_acc2_nxt;
                    r_acc3      <= w_acc3_nxt;
                    r_cnt1      <= w_acc1_nxt;
                    r_cnt2      <= w_acc2_nxt;
                    r_cnt3      <= w_acc3_nxt;
                    r_res_valid <= 1'b1;
                    r_fsm_x     <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fsm_x     = r_fsm_x;
    assign fsm_rst   = r_fsm_rst;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = r_res_valid;
    assign cnt1      = r_cnt1;
    assign cnt2      = r_cnt2;
    assign cnt3      = r_cnt3;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb/tb_seq_stream_ctrl.sv - self-checking bench for seq_stream_ctrl

module tb_seq_stream_ctrl;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(WORD_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_clr = 1'b0;
    logic              in_ready;
    logic              fsm_x;
    logic              fsm_rst;
    logic [1:0]        fsm_y;
    logic              busy;
    logic              res_valid;
    logic [CW-1:0]     cnt1;
    logic [CW-1:0]     cnt2;
    logic [CW-1:0]     cnt3;

    seq_stream_ctrl #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_clr    (in_clr),
        .in_ready  (in_ready),
        .fsm_x     (fsm_x),
        .fsm_rst   (fsm_rst),
        .fsm_y     (fsm_y),
        .busy      (busy),
        .res_valid (res_valid),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FSM stand-in: y is a function of x delayed by one and two cycles.
    logic xd1 = 1'b0;
    logic xd2 = 1'b0;
    always @(posedge clk) begin
        xd1 <= fsm_x;
        xd2 <= xd1;
    end

    always_comb begin
        fsm_y = 2'b00;
        case (mode)
            0: fsm_y = {1'b0, xd1};
            1: fsm_y = 2'b11;
            2: fsm_y = {xd2, xd1};
            default: fsm_y = xd1 ? 2'b10 : 2'b01;
        endcase
    end

    typedef struct {
        int cyc;
        int c1;
        int c2;
        int c3;
    } res_t;

    typedef struct {
        logic [WORD_W-1:0] w;
        int                mode;
    } exp_t;

    res_t res_q[$];
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (res_valid) res_q.push_back('{cyc, int'(cnt1), int'(cnt2), int'(cnt3)});
    end

    // Reference: sample k (0..WORD_W-1) is the response after bit WORD_W-1-k;
    // the cycle before the MSB always drives x=0.
    task automatic model(input logic [WORD_W-1:0] w, input int md,
                         output int c1, output int c2, output int c3);
        logic [WORD_W:0] ext;
        int d1, d2, y;
        ext = {1'b0, w};
        c1 = 0; c2 = 0; c3 = 0;
        for (int k = 0; k < WORD_W; k++) begin
            d1 = int'(ext[WORD_W-1-k]);
            d2 = int'(ext[WORD_W-k]);
            case (md)
                0: y = d1;
                1: y = 3;
                2: y = 2 * d2 + d1;
                default: y = d1 ? 2 : 1;
            endcase
            if (y == 1) c1++;
            if (y == 2) c2++;
            if (y == 3) c3++;
        end
        if (c1 > WORD_W) c1 = WORD_W;
        if (c2 > WORD_W) c2 = WORD_W;
        if (c3 > WORD_W) c3 = WORD_W;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    // with in_valid still high.
    task automatic push(input logic [WORD_W-1:0] w, input logic c, output int pc);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        in_clr   = c;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_timeout", longint'(in_ready), 1);
        @(negedge clk);
        pc = cyc;
        exp_q.push_back('{w, mode});
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (res_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("result_timeout", longint'(res_q.size() >= n), 1);
    endtask

    task automatic check_results();
        res_t r;
        exp_t e;
        int c1, c2, c3;
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            model(e.w, e.mode, c1, c2, c3);
            chk("cnt1", r.c1, c1);
            chk("cnt2", r.c2, c2);
            chk("cnt3", r.c3, c3);
        end
        chk("leftover_results", res_q.size(), 0);
        chk("missing_results", exp_q.size(), 0);
    endtask

    initial begin
        int pc;
        int t;
        int rsz;
        logic [WORD_W-1:0] w;
        int spacing[$];

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        chk("rst_fsm_rst", fsm_rst, 1);
        chk("rst_fsm_x", fsm_x, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cnts", {cnt1, cnt2, cnt3}, 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_fsm_rst_held", fsm_rst, 1);
        @(negedge clk);
        chk("rel_fsm_rst_drop", fsm_rst, 0);

        // Alternating word with CLR, y = {0, x delayed}.
        mode = 0;
        w = 32'hAAAA_AAAA;
        push(w, 1'b1, pc);
        in_valid = 1'b0;
        for (int k = 1; k <= WORD_W + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("clr_cycle_rst", fsm_rst, 1);
                chk("clr_cycle_x", fsm_x, 0);
            end else begin
                chk("aa_bit", fsm_x, w[WORD_W + 1 - k]);
                chk("aa_rst_low", fsm_rst, 0);
            end
        end
        wait_results(1);
        chk("aa_latency", res_q[0].cyc - pc, WORD_W + 3);
        chk("aa_cnt1_direct", res_q[0].c1, 16);
        check_results();

        // All-zero word, no CLR, y constant 11: saturates at WORD_W.
        mode = 1;
        push('0, 1'b0, pc);
        in_valid = 1'b0;
        @(negedge clk);
        chk("noclr_rst_low", fsm_rst, 0);
        wait_results(1);
        chk("noclr_latency", res_q[0].cyc - pc, WORD_W + 2);
        chk("sat_cnt3_direct", res_q[0].c3, WORD_W);
        check_results();

        // y = 10 for 31 samples, 01 for the DRAIN sample.
        mode = 3;
        push(32'hFFFF_FFFE, 1'b1, pc);
        in_valid = 1'b0;
        wait_results(1);
        chk("mix_cnt2_direct", res_q[0].c2, WORD_W - 1);
        chk("mix_cnt1_direct", res_q[0].c1, 1);
        check_results();

        // Fill the FIFO while a word is in flight.
        mode = 2;
        push($urandom, 1'b0, pc);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) push($urandom, 1'b0, pc);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        push($urandom, 1'b0, pc);
        in_valid = 1'b0;
        wait_results(6);
        for (int i = 1; i < 6; i++) spacing.push_back(res_q[i].cyc - res_q[i-1].cyc);
        foreach (spacing[i]) chk("b2b_spacing", spacing[i], WORD_W + 2);
        check_results();

        // Random words with random CLR, fed as fast as in_ready allows.
        for (int i = 0; i < 12; i++) begin
            push($urandom, ($urandom_range(0, 3) == 0), pc);
        end
        in_valid = 1'b0;
        wait_results(12);
        check_results();
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_after_random", busy, 0);

        // Reset in the middle of a word with two more queued.
        push($urandom, 1'b1, pc);
        push($urandom, 1'b0, t);
        push($urandom, 1'b0, t);
        in_valid = 1'b0;
        t = 0;
        while (cyc < pc + 18 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("midword_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_x", fsm_x, 0);
        chk("midrst_fsm_rst", fsm_rst, 1);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        rsz = res_q.size();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrel_fsm_rst", fsm_rst, 0);
        repeat (40) @(negedge clk);
        chk("midrel_no_result", res_q.size(), rsz);
        chk("midrel_busy", busy, 0);
        chk("midrel_cnts", {cnt1, cnt2, cnt3}, 0);
        push($urandom, 1'b0, pc);
        in_valid = 1'b0;
        @(negedge clk);
        chk("first_after_rst_clr", fsm_rst, 1);
        wait_results(1);
        chk("first_after_rst_latency", res_q[0].cyc - pc, WORD_W + 3);
        check_results();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
